// File: rtl/security_pkg.sv
// Shared types and constants for the security-core sequencer.
package security_pkg;

  localparam int SEC_DW    = 32;
  localparam int SEC_DEPTH = 8;

  // Sequencer states: load into LIFO, move LIFO->FIFO (pop/push pairs), drain FIFO.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    XFER_POP,
    XFER_PUSH,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sec_out_reg.sv
// One-entry output holding register with valid/ready handshake and a last flag.
// A loaded word stays on out_data until the downstream accepts it.
module sec_out_reg
  import security_pkg::*;
#(
  parameter int DW = SEC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;

  // Next-state: a load fills the slot, a handshake empties it; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_en) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/security_seq_ctrl.sv
// Sequencer for the security core: host packet -> LIFO, LIFO -> FIFO (word order
// reversed), FIFO -> output stream. All core strobes and status outputs are registered.
module security_seq_ctrl
  import security_pkg::*;
#(
  parameter int DW    = SEC_DW,
  parameter int DEPTH = SEC_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          core_wr1,
  output logic          core_rd1,
  output logic          core_wr2,
  output logic          core_rd2,
  output logic [DW-1:0] core_data_in,
  input  logic [DW-1:0] core_data_out,
  input  logic [DW-1:0] core_lifo_out,
  input  logic          core_fifo_full,
  input  logic          core_fifo_empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = '0;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;          // words loaded into the LIFO
  logic [CW-1:0] k_q, k_d;          // words moved LIFO -> FIFO
  logic [CW-1:0] r_q, r_d;          // words not yet accepted downstream
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr1_q, wr1_d;
  logic          rd1_q, rd1_d;
  logic          wr2_q, wr2_d;
  logic          rd2_q, rd2_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          rd1_dly_q;         // core_data_out carries the popped word this cycle
  logic          rd2_dly_q;         // core_lifo_out carries the popped word this cycle
  logic          err_seq_q, err_seq_d;

  logic          out_hs;
  logic          rd_room;
  logic          ld_en;
  logic          ld_last;

  // Next-state, counters and strobe decode for the whole sequence.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    r_d       = r_q;
    done_d    = 1'b0;
    wr1_d     = 1'b0;
    rd1_d     = 1'b0;
    wr2_d     = 1'b0;
    rd2_d     = 1'b0;
    data_in_d = data_in_q;
    err_seq_d = err_seq_q;
    ld_en     = 1'b0;
    ld_last   = 1'b0;
    out_hs    = out_valid && out_ready;
    // A new FIFO read may be issued when the slot is empty, or is being emptied
    // this cycle and at least one more word remains behind it.
    rd_room   = out_hs ? (r_q > ONE_C) : (!out_valid && (r_q != ZERO_C));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          n_d       = ZERO_C;
          k_d       = ZERO_C;
          r_d       = ZERO_C;
          err_seq_d = 1'b0;
        end
      end

      LOAD: begin
        if (in_valid && in_ready_q) begin
          wr2_d     = 1'b1;
          data_in_d = in_data;
          n_d       = n_q + ONE_C;
          if (in_last || (n_q + ONE_C == DEPTH_C)) begin
            state_d = XFER_POP;
            k_d     = ZERO_C;
          end
        end
      end

      XFER_POP: begin
        // A full FIFO means the core holds stale words; stall without strobing.
        if (core_fifo_full) begin
          err_seq_d = 1'b1;
        end else begin
          rd2_d   = 1'b1;
          state_d = XFER_PUSH;
        end
      end

      XFER_PUSH: begin
        // Wait out the registered strobe and core read latency, then push the word.
        if (rd2_dly_q) begin
          wr1_d     = 1'b1;
          data_in_d = core_lifo_out;
          k_d       = k_q + ONE_C;
          if (k_q + ONE_C == n_q) begin
            state_d = DRAIN;
            r_d     = n_q;
          end else begin
            state_d = XFER_POP;
          end
        end
      end

      DRAIN: begin
        if (rd1_dly_q) begin
          ld_en   = 1'b1;
          ld_last = (r_q == ONE_C);
        end
        if (out_hs) begin
          r_d = r_q - ONE_C;
          if (out_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        if (rd_room && !core_fifo_empty && !rd1_q && !rd1_dly_q) begin
          rd1_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      r_q        <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr1_q      <= 1'b0;
      rd1_q      <= 1'b0;
      wr2_q      <= 1'b0;
      rd2_q      <= 1'b0;
      data_in_q  <= '0;
      rd1_dly_q  <= 1'b0;
      rd2_dly_q  <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      r_q        <= r_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr1_q      <= wr1_d;
      rd1_q      <= rd1_d;
      wr2_q      <= wr2_d;
      rd2_q      <= rd2_d;
      data_in_q  <= data_in_d;
      rd1_dly_q  <= rd1_q;
      rd2_dly_q  <= rd2_q;
      err_seq_q  <= err_seq_d;
    end
  end

  sec_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (ld_en),
    .load_data(core_data_out),
    .load_last(ld_last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last)
  );

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign core_wr1     = wr1_q;
  assign core_rd1     = rd1_q;
  assign core_wr2     = wr2_q;
  assign core_rd2     = rd2_q;
  assign core_data_in = data_in_q;

endmodule

// File: tb/tb_security_seq_ctrl.sv
// Bench for security_seq_ctrl: behavioural core (FIFO/LIFO queues), a packet-level
// reference model checked every cycle, and directed packets with literal expectations.
module tb_security_seq_ctrl;
  import security_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, busy, done;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          core_wr1, core_rd1, core_wr2, core_rd2;
  logic [DW-1:0] core_data_in, core_data_out, core_lifo_out;
  logic          core_fifo_full, core_fifo_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  // Reference model state (packet level).
  logic [DW-1:0] fifo_m[$];
  logic [DW-1:0] lifo_m[$];
  logic [DW-1:0] ld_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] ref_q[$];
  logic          got_last;
  logic          exp_busy, exp_loading, exp_done, nxt_done;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  int            strobes;

  always #5 clk = ~clk;

  security_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .core_wr1       (core_wr1),
    .core_rd1       (core_rd1),
    .core_wr2       (core_wr2),
    .core_rd2       (core_rd2),
    .core_data_in   (core_data_in),
    .core_data_out  (core_data_out),
    .core_lifo_out  (core_lifo_out),
    .core_fifo_full (core_fifo_full),
    .core_fifo_empty(core_fifo_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event did not happen at %0t", name, $time);
  endtask

  // Behavioural security core: FIFO and LIFO with one-cycle registered read data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_m.delete();
      lifo_m.delete();
      core_data_out   <= '0;
      core_lifo_out   <= '0;
      core_fifo_full  <= 1'b0;
      core_fifo_empty <= 1'b1;
    end else begin
      if (core_wr1) fifo_m.push_back(core_data_in);
      if (core_rd1 && fifo_m.size() > 0) core_data_out <= fifo_m.pop_front();
      if (core_wr2) lifo_m.push_back(core_data_in);
      if (core_rd2 && lifo_m.size() > 0) core_lifo_out <= lifo_m.pop_back();
      core_fifo_full  <= (fifo_m.size() == DEPTH);
      core_fifo_empty <= (fifo_m.size() == 0);
    end
  end

  // Downstream ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Every-cycle compare against the packet-level model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      ld_q.delete();
      exp_q.delete();
      exp_busy    = 1'b0;
      exp_loading = 1'b0;
      exp_done    = 1'b0;
      prev_stall  = 1'b0;
      prev_data   = '0;
    end else begin
      strobes = int'(core_wr1) + int'(core_rd1) + int'(core_wr2) + int'(core_rd2);
      chk("one_strobe", 32'(strobes <= 1), 32'd1);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("in_ready", 32'(in_ready), 32'(exp_loading));
      chk("done", 32'(done), 32'(exp_done));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) fail_now("spurious_out_word");
        else begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        end
      end

      nxt_done = 1'b0;
      if (done) done_cnt++;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        $display("[%0t] out word 0x%08h last=%0b", $time, out_data, out_last);
        got_q.push_back(out_data);
        got_last = out_last;
        nxt_done = (exp_q.size() == 1);
        void'(exp_q.pop_front());
      end
      if (exp_loading && in_valid) begin
        $display("[%0t] host word 0x%08h last=%0b", $time, in_data, in_last);
        ld_q.push_back(in_data);
        if (in_last || ld_q.size() == DEPTH) begin
          exp_loading = 1'b0;
          for (int i = ld_q.size() - 1; i >= 0; i--) exp_q.push_back(ld_q[i]);
          ld_q.delete();
        end
      end
      if (!exp_busy && start) begin
        exp_busy    = 1'b1;
        exp_loading = 1'b1;
      end else if (exp_done) begin
        exp_busy = 1'b0;
      end
      exp_done   = nxt_done;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) fail_now("host_handshake_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int s;
    s = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (done_cnt != s) return;
    end
    fail_now("done_timeout");
  endtask

  // Compare collected output words with the literal list in ref_q.
  task automatic check_words(input string tag);
    chk({tag, "_count"}, got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size(); i++)
      chk({tag, "_word"}, (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, ref_q[i]);
  endtask

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    got_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_strobes", 32'({core_wr1, core_rd1, core_wr2, core_rd2}), 32'd0);
    chk("rst_core_data_in", core_data_in, 32'd0);
    rst_n = 1'b1;

    // 1: three-word packet
    got_q.delete(); done_cnt = 0;
    do_start();
    send_word(32'h0078696E, 1'b0);
    send_word(32'h6368616F, 1'b0);
    send_word(32'h11112222, 1'b1);
    wait_done(200);
    ref_q.delete();
    ref_q.push_back(32'h11112222); ref_q.push_back(32'h6368616F); ref_q.push_back(32'h0078696E);
    check_words("t1");
    chk("t1_last_flag", 32'(got_last), 32'd1);
    @(negedge clk);
    chk("t1_done_pulses", done_cnt, 32'd1);

    // 2: single word
    got_q.delete(); done_cnt = 0;
    do_start();
    send_word(32'hDEADBEEF, 1'b1);
    wait_done(200);
    ref_q.delete(); ref_q.push_back(32'hDEADBEEF);
    check_words("t2");
    chk("t2_last_flag", 32'(got_last), 32'd1);
    @(negedge clk);
    chk("t2_busy_idle", 32'(busy), 32'd0);

    // 3: full DEPTH packet without in_last, ninth word left pending
    got_q.delete(); done_cnt = 0;
    do_start();
    for (int i = 0; i < DEPTH; i++) send_word(32'hA0000000 + 32'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h99999999;
    repeat (3) begin
      @(negedge clk);
      chk("t3_in_ready_after_depth", 32'(in_ready), 32'd0);
    end
    wait_done(400);
    in_valid = 1'b0;
    ref_q.delete();
    for (int i = DEPTH - 1; i >= 0; i--) ref_q.push_back(32'hA0000000 + 32'(i));
    check_words("t3");

    // 4: random downstream back-pressure
    got_q.delete(); done_cnt = 0;
    ready_mode = 1;
    do_start();
    for (int i = 1; i <= 5; i++) send_word(32'h50000000 + 32'(i), 1'(i == 5));
    wait_done(2000);
    ready_mode = 0;
    ref_q.delete();
    for (int i = 5; i >= 1; i--) ref_q.push_back(32'h50000000 + 32'(i));
    check_words("t4");

    // 5: reset during the LIFO->FIFO move, then a fresh packet
    do_start();
    for (int i = 0; i < 4; i++) send_word(32'h70000000 + 32'(i), 1'(i == 3));
    repeat (3) @(posedge clk);
    #2;
    chk("t5_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_strobes_in_reset", 32'({core_wr1, core_rd1, core_wr2, core_rd2}), 32'd0);
    chk("t5_busy_in_reset", 32'(busy), 32'd0);
    chk("t5_out_valid_in_reset", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete(); done_cnt = 0;
    do_start();
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b1);
    wait_done(200);
    ref_q.delete(); ref_q.push_back(32'h00000002); ref_q.push_back(32'h00000001);
    check_words("t5");

    // 6: start during DRAIN is ignored; out_ready held low for a while
    got_q.delete(); done_cnt = 0;
    ready_mode = 2;
    do_start();
    send_word(32'hC0000001, 1'b0);
    send_word(32'hC0000002, 1'b0);
    send_word(32'hC0000003, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) fail_now("t6_out_valid_timeout");
    end
    do_start();
    repeat (20) @(posedge clk);
    ready_mode = 0;
    wait_done(200);
    repeat (3) @(negedge clk);
    chk("t6_busy_after_done", 32'(busy), 32'd0);
    chk("t6_done_pulses", done_cnt, 32'd1);
    ref_q.delete();
    ref_q.push_back(32'hC0000003); ref_q.push_back(32'hC0000002); ref_q.push_back(32'hC0000001);
    check_words("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
